// File: rtl/exibe_sequencia.sv
// exibe_sequencia
// Playback engine for the memory game. It walks the sequence RAM from address 0
// up to the latched rodada. Each stored play is shown on the LEDs for T_ON cycles
// and is then blanked for T_OFF cycles. Completion is reported with a one-cycle
// pronto pulse.
//
// RAM timing: the RAM has a synchronous read. Its data appears one cycle after
// the address is presented. The address therefore has to be stable for one
// whole cycle before CARREGA captures dado_ram:
//   - For the first play, the address comes from OCIOSO (always 0).
//   - For each later play, endereco is incremented on the edge that enters
//     PROXIMO. PROXIMO is then the address-setup cycle for the following CARREGA.
//   - The final play leaves through FIM instead of PROXIMO. So endereco never
//     counts past rodada and never wraps.
module exibe_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 1000,
    parameter int T_OFF  = 500
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              parar,
    input  logic [ADDR_W-1:0] rodada,
    input  logic [DATA_W-1:0] dado_ram,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              exibindo,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    // The timer only has to reach the longer of the two display intervals.
    localparam int TIMER_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    // Timer value on the last cycle of each timed state.
    localparam logic [TIMER_W-1:0] ULTIMO_ON  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] ULTIMO_OFF = TIMER_W'(T_OFF - 1);

    // State codes double as the debug display value.
    localparam logic [2:0] OCIOSO  = 3'd0;
    localparam logic [2:0] CARREGA = 3'd1;
    localparam logic [2:0] ACENDE  = 3'd2;
    localparam logic [2:0] APAGA   = 3'd3;
    localparam logic [2:0] PROXIMO = 3'd4;
    localparam logic [2:0] FIM     = 3'd5;

    logic [2:0]         estadoReg;
    logic [2:0]         estadoNext;
    logic [TIMER_W-1:0] timerReg;
    logic [TIMER_W-1:0] timerNext;
    logic [ADDR_W-1:0]  rodadaReg;
    logic [ADDR_W-1:0]  rodadaNext;
    logic [ADDR_W-1:0]  enderecoNext;
    logic [DATA_W-1:0]  ledsNext;
    logic               ultimaJogada;

    // The play at the current address is the last one of this sequence.
    assign ultimaJogada = (endereco == rodadaReg);

    // Next-state logic; parar overrides every other transition.
    always_comb begin
        estadoNext = estadoReg;
        case (estadoReg)
            OCIOSO: begin
                if (iniciar) begin
                    estadoNext = CARREGA;
                end
            end
            CARREGA: begin
                estadoNext = ACENDE;
            end
            ACENDE: begin
                if (timerReg == ULTIMO_ON) begin
                    estadoNext = APAGA;
                end
            end
            APAGA: begin
                if (timerReg == ULTIMO_OFF) begin
                    estadoNext = ultimaJogada ? FIM : PROXIMO;
                end
            end
            PROXIMO: begin
                estadoNext = CARREGA;
            end
            FIM: begin
                estadoNext = OCIOSO;
            end
            default: begin
                estadoNext = OCIOSO;
            end
        endcase
        if (parar) begin
            estadoNext = OCIOSO;
        end
    end

    // Timer: counts only while a timed state persists; cleared on any state entry.
    always_comb begin
        timerNext = '0;
        if ((estadoNext == estadoReg) && ((estadoReg == ACENDE) || (estadoReg == APAGA))) begin
            timerNext = timerReg + 1'b1;
        end
    end

    // Datapath next values: address, LED image and the latched last index.
    always_comb begin
        enderecoNext = endereco;
        ledsNext     = leds;
        rodadaNext   = rodadaReg;
        case (estadoReg)
            OCIOSO: begin
                enderecoNext = '0;
                ledsNext     = '0;
                if (iniciar) begin
                    rodadaNext = rodada;
                end
            end
            CARREGA: begin
                // The RAM word for the current address is valid now.
                ledsNext = dado_ram;
            end
            ACENDE: begin
                if (estadoNext == APAGA) begin
                    ledsNext = '0;
                end
            end
            APAGA: begin
                ledsNext = '0;
                // Advance now so the RAM sees the new address during PROXIMO.
                if (estadoNext == PROXIMO) begin
                    enderecoNext = endereco + 1'b1;
                end
            end
            PROXIMO: begin
                ledsNext = '0;
            end
            FIM: begin
                enderecoNext = '0;
                ledsNext     = '0;
            end
            default: begin
                enderecoNext = '0;
                ledsNext     = '0;
            end
        endcase
        // An abort clears the display and does not latch a new round.
        if (parar) begin
            enderecoNext = '0;
            ledsNext     = '0;
            rodadaNext   = rodadaReg;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estadoReg <= OCIOSO;
            timerReg  <= '0;
            rodadaReg <= '0;
            endereco  <= '0;
            leds      <= '0;
        end else begin
            estadoReg <= estadoNext;
            timerReg  <= timerNext;
            rodadaReg <= rodadaNext;
            endereco  <= enderecoNext;
            leds      <= ledsNext;
        end
    end

    // Status outputs decoded from the current state.
    always_comb begin
        exibindo  = 1'b0;
        pronto    = 1'b0;
        db_estado = 4'hF;
        case (estadoReg)
            OCIOSO: begin
                db_estado = 4'd0;
            end
            CARREGA: begin
                db_estado = 4'd1;
                exibindo  = 1'b1;
            end
            ACENDE: begin
                db_estado = 4'd2;
                exibindo  = 1'b1;
            end
            APAGA: begin
                db_estado = 4'd3;
                exibindo  = 1'b1;
            end
            PROXIMO: begin
                db_estado = 4'd4;
                exibindo  = 1'b1;
            end
            FIM: begin
                db_estado = 4'd5;
                pronto    = 1'b1;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Testbench for exibe_sequencia (T_ON=3, T_OFF=2).
// A cycle-position model derives the expected outputs from the playback rules.
// Every play occupies PLAY cycles, and the model works out which play and
// which phase the current cycle falls in.
module tb_exibe_sequencia;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 3;
    localparam int T_OFF  = 2;
    localparam int PLAY   = 2 + T_ON + T_OFF;

    logic              clock    = 1'b0;
    logic              reset    = 1'b0;
    logic              iniciar  = 1'b0;
    logic              parar    = 1'b0;
    logic [ADDR_W-1:0] rodada   = '0;
    logic [DATA_W-1:0] dado_ram = '0;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              exibindo;
    logic              pronto;
    logic [3:0]        db_estado;

    int compared   = 0;
    int mismatched = 0;
    int cur        = 0;

    logic [DATA_W-1:0] mem [16];

    exibe_sequencia #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .T_ON   (T_ON),
        .T_OFF  (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .rodada    (rodada),
        .dado_ram  (dado_ram),
        .endereco  (endereco),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Sequence RAM with synchronous read.
    always @(posedge clock) dado_ram <= mem[endereco];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: active flag, cycle position since start (1 = first cycle), latched rodada.
    bit mActive = 1'b0;
    int mCycle  = 0;
    int mRod    = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mActive <= 1'b0;
            mCycle  <= 0;
        end else if (parar) begin
            mActive <= 1'b0;
        end else if (mActive) begin
            if (mCycle == (mRod + 1) * PLAY) mActive <= 1'b0;
            else mCycle <= mCycle + 1;
        end else if (iniciar) begin
            mActive <= 1'b1;
            mCycle  <= 1;
            mRod    <= int'(rodada);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    int          p, ph;
    logic [3:0]  eEnd, eLeds, eDb;
    logic        eEx, ePr;
    always @(negedge clock) begin
        eEnd = 4'd0; eLeds = 4'd0; eDb = 4'd0; eEx = 1'b0; ePr = 1'b0;
        if (mActive) begin
            p    = (mCycle - 1) / PLAY;
            ph   = (mCycle - 1) % PLAY;
            eEnd = 4'(p);
            if (ph == 0) eDb = 4'd1;
            else if (ph <= T_ON) begin
                eDb   = 4'd2;
                eLeds = mem[4'(p)];
            end else if (ph <= T_ON + T_OFF) eDb = 4'd3;
            else if (p == mRod) begin
                eDb = 4'd5;
                ePr = 1'b1;
            end else begin
                eDb  = 4'd4;
                eEnd = 4'(p + 1);
            end
            eEx = !ePr;
        end
        check("cyc_endereco", 8'(endereco), 8'(eEnd));
        check("cyc_leds", 8'(leds), 8'(eLeds));
        check("cyc_exibindo", 8'(exibindo), 8'(eEx));
        check("cyc_pronto", 8'(pronto), 8'(ePr));
        check("cyc_db_estado", 8'(db_estado), 8'(eDb));
    end

    task automatic startPlay();
        iniciar = 1'b1;
        @(posedge clock); #1;
        iniciar = 1'b0;
        cur = 1;
    endtask

    task automatic goCycle(input int k);
        while (cur < k) begin
            @(posedge clock); #1;
            cur++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check("rst_endereco", 8'(endereco), 8'h0);
        check("rst_leds", 8'(leds), 8'h0);
        check("rst_exibindo", 8'(exibindo), 8'h0);
        check("rst_pronto", 8'(pronto), 8'h0);
        check("rst_db_estado", 8'(db_estado), 8'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        // 1: single play
        mem[0] = 4'b0010; rodada = 4'd0;
        startPlay();
        check("t1_db_c1", 8'(db_estado), 8'd1);
        goCycle(2); check("t1_leds_c2", 8'(leds), 8'h2);
        goCycle(4); check("t1_leds_c4", 8'(leds), 8'h2);
        goCycle(5); check("t1_leds_c5", 8'(leds), 8'h0);
        goCycle(7); check("t1_pronto_c7", 8'(pronto), 8'h1);
        goCycle(8); check("t1_pronto_c8", 8'(pronto), 8'h0);
        check("t1_end_c8", 8'(endereco), 8'h0);

        // 2: three plays
        mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000; rodada = 4'd2;
        goCycle(10);
        startPlay();
        goCycle(2);  check("t2_leds_c2", 8'(leds), 8'h1);
        goCycle(8);  check("t2_end_c8", 8'(endereco), 8'h1);
        goCycle(9);  check("t2_leds_c9", 8'(leds), 8'h4);
        goCycle(16); check("t2_leds_c16", 8'(leds), 8'h8);
        check("t2_end_c16", 8'(endereco), 8'h2);
        goCycle(21); check("t2_pronto_c21", 8'(pronto), 8'h1);
        goCycle(22); check("t2_pronto_c22", 8'(pronto), 8'h0);

        // 3: abort during ACENDE of address 1
        goCycle(24);
        startPlay();
        goCycle(9); check("t3_leds_c9", 8'(leds), 8'h4);
        parar = 1'b1;
        goCycle(10);
        parar = 1'b0;
        check("t3_db_abort", 8'(db_estado), 8'h0);
        check("t3_leds_abort", 8'(leds), 8'h0);
        check("t3_end_abort", 8'(endereco), 8'h0);
        goCycle(35); check("t3_db_later", 8'(db_estado), 8'h0);

        // 4: asynchronous reset in APAGA, then restart
        mem[0] = 4'h3; mem[1] = 4'h9; rodada = 4'd1;
        startPlay();
        goCycle(5); check("t4_db_c5", 8'(db_estado), 8'd3);
        #2 reset = 1'b0;
        #1;
        check("t4_async_endereco", 8'(endereco), 8'h0);
        check("t4_async_leds", 8'(leds), 8'h0);
        check("t4_async_exibindo", 8'(exibindo), 8'h0);
        check("t4_async_db", 8'(db_estado), 8'h0);
        @(negedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        startPlay();
        goCycle(2);  check("t4_leds_c2", 8'(leds), 8'h3);
        goCycle(9);  check("t4_leds_c9", 8'(leds), 8'h9);
        goCycle(14); check("t4_pronto_c14", 8'(pronto), 8'h1);

        // 5: rodada change and iniciar re-pulse during playback are ignored
        goCycle(16);
        startPlay();
        goCycle(3);
        rodada = 4'd5; iniciar = 1'b1;
        goCycle(4);
        iniciar = 1'b0;
        goCycle(14); check("t5_pronto_c14", 8'(pronto), 8'h1);
        goCycle(15); check("t5_exibindo_c15", 8'(exibindo), 8'h0);
        check("t5_db_c15", 8'(db_estado), 8'h0);

        // 6: full-depth sequence, no wrap
        for (int i = 0; i < 16; i++) mem[i] = 4'(i * 7 + 3);
        rodada = 4'd15;
        goCycle(17);
        startPlay();
        goCycle(105); check("t6_end_c105", 8'(endereco), 8'hF);
        goCycle(107); check("t6_leds_c107", 8'(leds), 8'hC);
        goCycle(111); check("t6_end_c111", 8'(endereco), 8'hF);
        goCycle(112); check("t6_pronto_c112", 8'(pronto), 8'h1);
        check("t6_end_c112", 8'(endereco), 8'hF);
        goCycle(113); check("t6_end_c113", 8'(endereco), 8'h0);
        check("t6_pronto_c113", 8'(pronto), 8'h0);
        goCycle(116);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
